// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default and serializer state encoding for the serial comparator path.
package comparator_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} ser_state_t;
endpackage

// File: rtl/operand_serializer_piso.sv
// piso_shift_reg: WIDTH-bit parallel-in/serial-out register, MSB first, load has priority over shift.
module piso_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk)
    if (!rst) r_q <= '0;
    else if (load) r_q <= d;
    else if (shift) r_q <= {r_q[WIDTH-2:0], 1'b0};
  assign msb = r_q[WIDTH-1];
endmodule

// File: rtl/operand_serializer.sv
// operand_serializer: feeds operand pairs to the comparator bit-serially (MSB first) or in one parallel strobe.
// Define OPERAND_SERIALIZER_EARLY_STOP_EN to end a serial transfer at the first differing bit pair.
module operand_serializer
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic [WIDTH-1:0] par_a,
  output logic [WIDTH-1:0] par_b,
  output logic             par_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);
  ser_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_par_a, r_par_b;
  logic             w_accept, w_shift, w_msb_a, w_msb_b, w_last;
  assign w_accept = r_state == IDLE && r_in_ready && in_valid;
  assign w_shift  = r_state == SHIFT;
  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk(clk), .rst(rst), .load(w_accept), .shift(w_shift), .d(a), .msb(w_msb_a)
  );
  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk(clk), .rst(rst), .load(w_accept), .shift(w_shift), .d(b), .msb(w_msb_b)
  );
`ifdef OPERAND_SERIALIZER_EARLY_STOP_EN
  // lower bits cannot change the result once the pair differs
  assign w_last = w_shift && (r_cnt == '0 || w_msb_a != w_msb_b);
`else
  assign w_last = w_shift && r_cnt == '0;
`endif
  // in_ready is its own flop so it stays low for one cycle after reset release
  always_ff @(posedge clk)
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_par_a    <= '0;
      r_par_b    <= '0;
    end else begin
      r_in_ready <= r_state == DONE || (r_state == IDLE && !w_accept);
      if (w_accept) begin
        r_par_a <= a;
        r_par_b <= b;
        r_cnt   <= TOP;
      end else if (w_shift && !w_last) r_cnt <= r_cnt - CW'(1);
      r_state <= w_accept ? (mode ? SHIFT : PAR) :
                 r_state == SHIFT ? (w_last ? DONE : SHIFT) :
                 r_state == PAR ? DONE : IDLE;
    end
  assign in_ready  = r_in_ready;
  assign busy      = r_state != IDLE;
  assign bit_valid = w_shift;
  assign ser_a     = w_shift & w_msb_a;
  assign ser_b     = w_shift & w_msb_b;
  assign first_bit = w_shift && r_cnt == TOP;
  assign last_bit  = w_last;
  assign par_valid = r_state == PAR;
  assign done      = r_state == DONE;
  assign par_a     = r_par_a;
  assign par_b     = r_par_b;
endmodule
